// File: rtl/fp_div_vec_sequencer.sv
// rtl/fp_div_vec_sequencer.sv - operand table sequencer and tagged result collector for the fp divider
// Streams DEPTH operand pairs to the divider and returns each quotient tagged with its table index.
module fp_div_vec_sequencer #(
   parameter int W       = 32,
   parameter int DEPTH   = 8,
   parameter int MAX_OUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_a,
   input  logic [W-1:0]             wr_b,
   input  logic                     start,
   input  logic                     loop,
   input  logic                     stop,
   output logic                     op_valid,
   input  logic                     op_ready,
   output logic [W-1:0]             op_a,
   output logic [W-1:0]             op_b,
   input  logic                     ip_res_valid,
   output logic                     ip_res_ready,
   input  logic [W-1:0]             ip_res_data,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [W-1:0]             res_data,
   output logic [$clog2(DEPTH)-1:0] res_idx,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              nonfinite_cnt
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(MAX_OUT) + 1;
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  tab_a [DEPTH];
   logic [W-1:0]  tab_b [DEPTH];
   logic [IW-1:0] tag_mem [MAX_OUT];
   logic [IW-1:0] iss_idx;
   logic          loop_r;
   logic [CW-1:0] out_cnt;
   logic [PW-1:0] tag_wr_ptr, tag_rd_ptr;
   logic          idle_or_done, start_ok, op_hs, ip_hs, res_take, last_iss;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
   endfunction

   assign idle_or_done = (state == IDLE) || (state == DONE);
   assign start_ok     = start && idle_or_done;
   assign op_valid     = (state == RUN) && (out_cnt < CW'(MAX_OUT));
   assign op_a         = op_valid ? tab_a[iss_idx] : '0;
   assign op_b         = op_valid ? tab_b[iss_idx] : '0;
   assign op_hs        = op_valid && op_ready;
   assign ip_res_ready = !res_valid || res_ready;
   assign ip_hs        = ip_res_valid && ip_res_ready;
   // Results with no tag outstanding belong to a run cut short by reset: accept and drop them.
   assign res_take     = ip_hs && (out_cnt != '0);
   assign last_iss     = !loop_r && (iss_idx == IW'(DEPTH - 1));
   assign busy         = (state == RUN) || (state == DRAIN);
   assign done         = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if ((loop_r && stop) || (op_hs && last_iss)) state_nxt = DRAIN;
         DRAIN:   if ((out_cnt == '0) && !res_valid) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Table and tag storage carry no reset; their contents are only observed once written.
   always_ff @(posedge clk) begin
      if (wr_en && idle_or_done) begin
         tab_a[wr_addr] <= wr_a;
         tab_b[wr_addr] <= wr_b;
      end
      if (op_hs) tag_mem[tag_wr_ptr] <= iss_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_idx    <= '0;
         loop_r     <= 1'b0;
         out_cnt    <= '0;
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
      end else begin
         if (start_ok) begin
            iss_idx <= '0;
            loop_r  <= loop;
         end else if (op_hs) begin
            iss_idx <= iss_idx + IW'(1);
         end
         if (op_hs && !res_take)      out_cnt <= out_cnt + CW'(1);
         else if (!op_hs && res_take) out_cnt <= out_cnt - CW'(1);
         if (op_hs)    tag_wr_ptr <= ptr_inc(tag_wr_ptr);
         if (res_take) tag_rd_ptr <= ptr_inc(tag_rd_ptr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_idx       <= '0;
         nonfinite_cnt <= '0;
      end else begin
         if (res_take) begin
            res_valid <= 1'b1;
            res_data  <= ip_res_data;
            res_idx   <= tag_mem[tag_rd_ptr];
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
         if (start_ok)
            nonfinite_cnt <= '0;
         else if (res_take && (ip_res_data[W-2 -: 8] == 8'hFF) && (nonfinite_cnt != 16'hFFFF))
            nonfinite_cnt <= nonfinite_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fp_div_vec_sequencer.sv
// tb/tb_fp_div_vec_sequencer.sv - randomized self-checking bench for fp_div_vec_sequencer
// Drives a latency-configurable in-order divider model and scores tagged results against a queue model.
module tb_fp_div_vec_sequencer;

   localparam int W       = 32;
   localparam int DEPTH   = 8;
   localparam int MAX_OUT = 4;

   logic          clk = 1'b0;
   logic          rst, wr_en, start, loop, stop;
   logic [2:0]    wr_addr;
   logic [W-1:0]  wr_a, wr_b;
   logic          op_valid, op_ready, ip_res_valid, ip_res_ready, res_valid, res_ready, busy, done;
   logic [W-1:0]  op_a, op_b, ip_res_data, res_data;
   logic [2:0]    res_idx;
   logic [15:0]   nonfinite_cnt;

   fp_div_vec_sequencer #(.W(W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
      .start(start), .loop(loop), .stop(stop),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .ip_res_valid(ip_res_valid), .ip_res_ready(ip_res_ready), .ip_res_data(ip_res_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
      .busy(busy), .done(done), .nonfinite_cnt(nonfinite_cnt)
   );

   always #5 clk = ~clk;

   int          n_tests = 0, n_fail = 0;
   logic [31:0] tab_a_m [DEPTH];
   logic [31:0] tab_b_m [DEPTH];
   logic [31:0] exp_d[$], ip_d[$], got_d[$];
   int          exp_i[$], ip_due[$], got_i[$];
   int          cyc = 0, lat, p_op, p_res, issued, outst, max_outst, nres, nf_m;
   bit          active = 0, halted = 0, lp_m = 0, hold_chk = 0;
   logic [31:0] hold_d;
   logic [2:0]  hold_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:0] == 31'd0) return 0.0;
      e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Operands are chosen so every finite quotient is exact in single precision.
   function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
      if (b[30:0] == 31'd0) return {a[31] ^ b[31], 8'hFF, 23'd0};
      return r2f(f2r(a) / f2r(b));
   endfunction

   function automatic logic [31:0] rand_num();
      logic [31:0] v;
      v = r2f(real'($urandom_range(1, 1000)));
      v[31] = $urandom_range(0, 1);
      return v;
   endfunction

   function automatic logic [31:0] rand_den();
      logic [31:0] v;
      int          e;
      e = $urandom_range(0, 6) - 3;
      v = ($urandom_range(0, 7) == 0) ? 32'd0 : r2f(2.0 ** e);
      v[31] = $urandom_range(0, 1);
      return v;
   endfunction

   task automatic write_vec(input int idx, input logic [31:0] a, input logic [31:0] b);
      wr_en = 1; wr_addr = idx[2:0]; wr_a = a; wr_b = b;
      @(posedge clk); #1; cyc++;
      wr_en = 0;
      tab_a_m[idx] = a; tab_b_m[idx] = b;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_op_valid"}, op_valid, 0);
      check({pfx, "_op_a"}, op_a, 0);
      check({pfx, "_op_b"}, op_b, 0);
      check({pfx, "_ip_res_ready"}, ip_res_ready, 1);
      check({pfx, "_res_valid"}, res_valid, 0);
      check({pfx, "_res_data"}, res_data, 0);
      check({pfx, "_res_idx"}, res_idx, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_nonfinite"}, nonfinite_cnt, 0);
   endtask

   // One clock: drive environment, score handshakes, advance to just after the next edge.
   task automatic step();
      bit          op_hs, ip_hs, res_hs;
      logic [31:0] ed;
      op_ready  = ($urandom_range(0, 99) < p_op);
      res_ready = ($urandom_range(0, 99) < p_res);
      if (ip_d.size() > 0 && ip_due[0] <= cyc) begin
         ip_res_valid = 1; ip_res_data = ip_d[0];
      end else begin
         ip_res_valid = 0; ip_res_data = $urandom;
      end
      #1;
      check("op_valid", op_valid,
            active && !halted && (lp_m || issued < DEPTH) && outst < MAX_OUT);
      if (hold_chk) begin
         check("hold_valid", res_valid, 1);
         check("hold_data", res_data, hold_d);
         check("hold_idx", res_idx, hold_i);
      end
      op_hs  = op_valid && op_ready;
      ip_hs  = ip_res_valid && ip_res_ready;
      res_hs = res_valid && res_ready;
      if (ip_hs) begin
         void'(ip_d.pop_front()); void'(ip_due.pop_front());
         if (outst > 0) outst--;
      end
      if (op_hs) begin
         int idx = issued % DEPTH;
         check("op_a", op_a, tab_a_m[idx]);
         check("op_b", op_b, tab_b_m[idx]);
         ip_d.push_back(quot(op_a, op_b));
         ip_due.push_back(cyc + lat);
         exp_d.push_back(quot(tab_a_m[idx], tab_b_m[idx]));
         exp_i.push_back(idx);
         issued++; outst++;
      end
      if (res_hs) begin
         check("res_expected", exp_d.size() > 0, 1);
         if (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            check("res_data", res_data, ed);
            check("res_idx", res_idx, exp_i.pop_front());
            if (ed[30:23] == 8'hFF) nf_m++;
         end
         got_d.push_back(res_data); got_i.push_back(res_idx);
         nres++;
      end
      hold_chk = res_valid && !res_ready;
      hold_d = res_data; hold_i = res_idx;
      if (outst > max_outst) max_outst = outst;
      if (lp_m && active && stop) halted = 1;
      @(posedge clk); #1; cyc++;
   endtask

   task automatic run(input bit lp, input int lt, input int pop, input int pres,
                      input int stop_at, input int rst_at, input bit wr_run);
      int budget = 0;
      lat = lt; p_op = pop; p_res = pres; lp_m = lp;
      loop = lp; start = 1;
      step();
      start = 0;
      active = 1; halted = 0; issued = 0; nf_m = 0; max_outst = 0; nres = 0;
      got_d.delete(); got_i.delete();
      check("busy_after_start", busy, 1);
      check("done_after_start", done, 0);
      while (done !== 1'b1 && budget < 3000) begin
         if (rst_at > 0 && issued == rst_at) begin
            rst = 1; #1;
            check_reset_outputs("midrun_rst");
            @(posedge clk); #1; cyc++;
            rst = 0;
            active = 0; outst = 0; hold_chk = 0;
            exp_d.delete(); exp_i.delete();
            p_res = 100;
            for (int k = 0; k < 100 && ip_d.size() > 0; k++) step();
            check("stray_drained", ip_d.size(), 0);
            check("stray_no_result", nres, 0);
            check("stray_nonfinite", nonfinite_cnt, 0);
            return;
         end
         stop  = lp && issued >= stop_at && !halted;
         wr_en = wr_run && budget == 0;
         wr_addr = 3'd5; wr_a = 32'hDEADBEEF; wr_b = 32'h3F800000;
         step();
         wr_en = 0;
         budget++;
      end
      stop = 0;
      active = 0;
      check("run_done", done, 1);
      check("run_busy_low", busy, 0);
      check("run_all_results", exp_d.size(), 0);
      check("run_nonfinite", nonfinite_cnt, nf_m);
   endtask

   initial begin
      rst = 1; wr_en = 0; wr_addr = 0; wr_a = 0; wr_b = 0; start = 0; loop = 0; stop = 0;
      op_ready = 0; ip_res_valid = 0; ip_res_data = 0; res_ready = 0;
      lat = 1; p_op = 100; p_res = 100; issued = 0; outst = 0; max_outst = 0; nres = 0; nf_m = 0;
      @(posedge clk); #1; cyc++;
      check_reset_outputs("reset");
      rst = 0;
      @(posedge clk); #1; cyc++;

      // Single pass, full throughput, all finite.
      write_vec(0, 32'h40C00000, 32'h40000000);
      for (int i = 1; i < DEPTH; i++) begin
         logic [31:0] d = rand_den();
         if (d[30:0] == 31'd0) d = 32'h3F800000;
         write_vec(i, rand_num(), d);
      end
      run(0, 1, 100, 100, 0, 0, 0);
      check("p1_nres", nres, 8);
      check("p1_first_data", got_d[0], 32'h40400000);
      check("p1_first_idx", got_i[0], 0);
      check("p1_last_idx", got_i[7], 7);
      check("p1_nonfinite", nonfinite_cnt, 0);

      // Divide by zero in vector 3.
      write_vec(3, 32'h3F800000, 32'h00000000);
      run(0, 1, 100, 100, 0, 0, 0);
      check("p2_v3_data", got_d[3], 32'h7F800000);
      check("p2_v3_idx", got_i[3], 3);
      check("p2_nonfinite", nonfinite_cnt, 1);

      // Long IP latency: issue stalls at MAX_OUT outstanding.
      run(0, 10, 100, 100, 0, 0, 0);
      check("p3_max_outstanding", max_outst, MAX_OUT);
      check("p3_nres", nres, 8);

      // Random table, backpressure both sides, table write attempted mid-run.
      for (int i = 0; i < DEPTH; i++) write_vec(i, rand_num(), rand_den());
      run(0, 4, 60, 33, 0, 0, 1);
      check("p4_nres", nres, 8);

      // Loop mode stopped after 20 issues.
      for (int i = 0; i < DEPTH; i++) write_vec(i, rand_num(), rand_den());
      run(1, 3, 75, 70, 20, 0, 0);
      check("p5_issued_20_or_21", (issued == 20 || issued == 21), 1);
      check("p5_nres", nres, issued);
      check("p5_wrap1_idx", got_i[8], 0);
      check("p5_wrap2_idx", got_i[16], 0);

      // Reset with three divides in flight, then a clean pass.
      run(0, 10, 100, 100, 0, 3, 0);
      run(0, 2, 100, 100, 0, 0, 0);
      check("p6_nres", nres, 8);
      check("p6_first_idx", got_i[0], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
